// File: rtl/mac_pkg.sv
// Shared state encoding and default widths for the MAC operand feeder.
package mac_pkg;

    localparam int unsigned BW_DEF      = 4;
    localparam int unsigned PSUM_BW_DEF = 16;
    localparam int unsigned LEN_BW_DEF  = 8;
    localparam int unsigned N_ELEM      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mac_feeder.sv
// Feeds 4-element operand groups to an external MAC array and accumulates its results.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int unsigned bw      = BW_DEF,
    parameter int unsigned psum_bw = PSUM_BW_DEF,
    parameter int unsigned len_bw  = LEN_BW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [len_bw-1:0]     len,
    input  logic [psum_bw-1:0]    bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_ELEM*bw-1:0]  in_a,
    input  logic [N_ELEM*bw-1:0]  in_b,
    output logic [bw-1:0]         a1,
    output logic [bw-1:0]         a2,
    output logic [bw-1:0]         a3,
    output logic [bw-1:0]         a4,
    output logic [bw-1:0]         b1,
    output logic [bw-1:0]         b2,
    output logic [bw-1:0]         b3,
    output logic [bw-1:0]         b4,
    output logic [psum_bw-1:0]    c,
    input  logic [psum_bw-1:0]    mac_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [psum_bw-1:0]    res_data,
    output logic                  busy
);

    state_e                        state_q, state_d;
    logic [len_bw-1:0]             len_q, len_d;
    logic [len_bw-1:0]             cnt_q, cnt_d;
    logic [psum_bw-1:0]            bias_q, bias_d;
    logic [psum_bw-1:0]            acc_q, acc_d;
    logic [1:0]                    vld_q, vld_d;
    logic [N_ELEM-1:0][bw-1:0]     a_q, a_d;
    logic [N_ELEM-1:0][bw-1:0]     b_q, b_d;
    logic [psum_bw-1:0]            c_q, c_d;
    logic [psum_bw-1:0]            res_data_q, res_data_d;
    logic                          res_valid_q, res_valid_d;
    logic                          in_ready_q, in_ready_d;
    logic                          busy_q, busy_d;
    logic                          hs;

    assign hs = in_valid & in_ready_q;

    // Next-state, operand, pipeline and accumulator logic.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        bias_d     = bias_q;
        acc_d      = acc_q;
        vld_d      = {vld_q[0], hs};
        a_d        = '0;
        b_d        = '0;
        c_d        = '0;
        res_data_d = res_data_q;

        // A group accepted two edges ago has its MAC result on mac_out now.
        if (vld_q[1]) begin
            acc_d = acc_q + mac_out;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = len;
                    bias_d = bias;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (len == '0) begin
                        state_d    = DONE;
                        res_data_d = bias;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (hs) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    c_d   = (cnt_q == '0) ? bias_q : '0;
                    cnt_d = cnt_q + len_bw'(1);
                    if (cnt_q + len_bw'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Final group's contribution lands on this edge.
                if (vld_q == 2'b10) begin
                    state_d    = DONE;
                    res_data_d = acc_d;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == FEED);
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any job in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            vld_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            vld_q       <= vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign a1        = a_q[0];
    assign a2        = a_q[1];
    assign a3        = a_q[2];
    assign a4        = a_q[3];
    assign b1        = b_q[0];
    assign b2        = b_q[1];
    assign b3        = b_q[2];
    assign b4        = b_q[3];
    assign c         = c_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a behavioural MAC array beside it.
module tb_mac_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [15:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  a1, a2, a3, a4, b1, b2, b3, b4;
    logic [15:0] c;
    logic [15:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] ga [16];
    logic [15:0] gb [16];

    always #5 clk = ~clk;

    mac_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .a4        (a4),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .b4        (b4),
        .c         (c),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // Registered MAC array: samples operands at an edge, result visible after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mac_out <= '0;
        else       mac_out <= 16'(16'(a1) * 16'(b1) + 16'(a2) * 16'(b2) +
                              16'(a3) * 16'(b3) + 16'(a4) * 16'(b4) + c);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: bias plus the dot products of every group, modulo 2^16.
    function automatic logic [15:0] model(input int n, input logic [15:0] bi);
        int unsigned s = 32'(bi);
        for (int g = 0; g < n; g++)
            for (int k = 0; k < 4; k++)
                s += ga[g][4*k +: 4] * gb[g][4*k +: 4];
        return 16'(s);
    endfunction

    function automatic void fill_random(input int n);
        for (int g = 0; g < n; g++) begin
            ga[g] = 16'h0;
            gb[g] = 16'h0;
            for (int k = 0; k < 4; k++) begin
                ga[g][4*k +: 4] = 4'($urandom_range(3, 0));
                gb[g][4*k +: 4] = 4'($urandom_range(3, 0));
            end
        end
    endfunction

    function automatic void fill_const(input int n, input logic [15:0] av, input logic [15:0] bv);
        for (int g = 0; g < n; g++) begin
            ga[g] = av;
            gb[g] = bv;
        end
    endfunction

    // One complete job: start, feed n groups with gaps, check result, hold, accept.
    task automatic run_job(input string nm, input int n, input logic [15:0] bi,
                           input int gap, input bit rnd, input int hold);
        logic [15:0] expv;
        int rdy_cnt, feed_cycles, ng;
        expv        = model(n, bi);
        rdy_cnt     = 0;
        feed_cycles = 0;
        start = 1'b1; len = 8'(n); bias = bi;
        step();
        start = 1'b0;
        chk({nm, "_busy_start"}, 32'(busy), 32'd1);
        if (n == 0) begin
            chk({nm, "_zero_valid"}, 32'(res_valid), 32'd1);
            chk({nm, "_zero_data"}, 32'(res_data), 32'(bi));
            chk({nm, "_zero_rdy"}, 32'(in_ready), 32'd0);
        end else begin
            for (int g = 0; g < n; g++) begin
                ng = rnd ? int'($urandom_range(gap, 0)) : ((g > 0) ? gap : 0);
                for (int i = 0; i < ng; i++) begin
                    if (in_ready) rdy_cnt++;
                    feed_cycles++;
                    chk({nm, "_gap_rdy"}, 32'(in_ready), 32'd1);
                    in_valid = 1'b0;
                    step();
                    chk({nm, "_gap_ops"}, {a4, a3, a2, a1, b4, b3, b2, b1}, 32'd0);
                    chk({nm, "_gap_c"}, 32'(c), 32'd0);
                end
                if (in_ready) rdy_cnt++;
                feed_cycles++;
                chk({nm, "_feed_rdy"}, 32'(in_ready), 32'd1);
                in_valid = 1'b1; in_a = ga[g]; in_b = gb[g];
                step();
                in_valid = 1'b0;
                chk({nm, "_ops_a"}, 32'({a4, a3, a2, a1}), 32'(ga[g]));
                chk({nm, "_ops_b"}, 32'({b4, b3, b2, b1}), 32'(gb[g]));
                chk({nm, "_ops_c"}, 32'(c), (g == 0) ? 32'(bi) : 32'd0);
            end
            chk({nm, "_drain_rdy"}, 32'(in_ready), 32'd0);
            chk({nm, "_drain_valid"}, 32'(res_valid), 32'd0);
            step();
            chk({nm, "_t1_valid"}, 32'(res_valid), 32'd0);
            chk({nm, "_t1_rdy"}, 32'(in_ready), 32'd0);
            step();
            chk({nm, "_t2_valid"}, 32'(res_valid), 32'd1);
            chk({nm, "_t2_data"}, 32'(res_data), 32'(expv));
            chk({nm, "_rdy_count"}, 32'(rdy_cnt), 32'(feed_cycles));
        end
        for (int i = 0; i < hold; i++) begin
            start = (i == 1); len = 8'd5; bias = 16'hAAAA; res_ready = 1'b0;
            step();
            start = 1'b0;
            chk({nm, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({nm, "_hold_data"}, 32'(res_data), 32'(expv));
            chk({nm, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({nm, "_acc_valid"}, 32'(res_valid), 32'd0);
        chk({nm, "_acc_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_ops", {a4, a3, a2, a1, b4, b3, b2, b1}, 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // len=1, bias=5, a={1,2,3,4}, b=1s -> 15
        ga[0] = 16'h4321; gb[0] = 16'h1111;
        run_job("single", 1, 16'd5, 0, 1'b0, 1);

        // len=3, a=1, b=2, no gaps -> 24
        fill_const(3, 16'h1111, 16'h2222);
        run_job("three", 3, 16'd0, 0, 1'b0, 0);

        // len=2, 3-cycle gap, a=2, b=3, bias=1 -> 49
        fill_const(2, 16'h2222, 16'h3333);
        run_job("gap", 2, 16'd1, 3, 1'b0, 0);

        // len=0 -> bias returned; held with start pulsed
        run_job("zero", 0, 16'h1234, 0, 1'b0, 4);

        // wrap-around: 0xFFFF + 1 -> 0
        ga[0] = 16'h0001; gb[0] = 16'h0001;
        run_job("wrap", 1, 16'hFFFF, 0, 1'b0, 0);

        // reset mid-job abandons it
        fill_const(3, 16'h3333, 16'h3333);
        start = 1'b1; len = 8'd3; bias = 16'd7;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_a = ga[0]; in_b = gb[0];
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_rdy", 32'(in_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_data", 32'(res_data), 32'd0);
        chk("midrst_ops", {a4, a3, a2, a1, b4, b3, b2, b1}, 32'd0);
        chk("midrst_c", 32'(c), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("postrst_valid", 32'(res_valid), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end
        fill_const(1, 16'h1111, 16'h1111);
        run_job("after_rst", 1, 16'd0, 0, 1'b0, 0);

        // randomized jobs against the reference model
        for (int j = 0; j < 8; j++) begin
            int n;
            n = (j == 3) ? 0 : int'($urandom_range(6, 1));
            fill_random(n);
            run_job("rand", n, 16'($urandom()), 2, 1'b1, int'($urandom_range(2, 0)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
